// File: rtl/uart_rx_if.sv
// Receive-side output bundle of the UART receiver: the received byte, its
// completion strobe and the framing-error flag.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] dout;
    logic                 rx_done;
    logic                 frame_err;

    modport master (output dout, output rx_done, output frame_err);
    modport slave  (input  dout, input  rx_done, input  frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples the synchronized line at bit centres using the
// oversampling tick and delivers each byte with a one-clock rx_done strobe.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      s_tick,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick_mid, tick_last, bit_last;
    logic                 tick_clr, tick_inc, bit_clr, bit_inc, shift_en, load_out;

    assign tick_mid  = (tick_cnt == TICK_MID);
    assign tick_last = (tick_cnt == TICK_LAST);
    assign bit_last  = (bit_cnt == BIT_LAST);

    // Line idles high, so the synchronizer resets to 1 to avoid a fake start edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx_s) state_next = START;
            START: if (s_tick && tick_mid) state_next = rx_s ? IDLE : DATA;
            DATA:  if (s_tick && tick_last && bit_last) state_next = STOP;
            STOP:  if (s_tick && tick_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tick_clr = 1'b0;
        tick_inc = 1'b0;
        bit_clr  = 1'b0;
        bit_inc  = 1'b0;
        shift_en = 1'b0;
        load_out = 1'b0;
        case (state)
            IDLE: tick_clr = !rx_s;
            START: if (s_tick) begin
                if (tick_mid) begin
                    tick_clr = 1'b1;
                    bit_clr  = 1'b1;
                end else begin
                    tick_inc = 1'b1;
                end
            end
            DATA: if (s_tick) begin
                if (tick_last) begin
                    tick_clr = 1'b1;
                    shift_en = 1'b1;
                    bit_inc  = !bit_last;
                end else begin
                    tick_inc = 1'b1;
                end
            end
            STOP: if (s_tick) begin
                if (tick_last) begin
                    tick_clr = 1'b1;
                    load_out = 1'b1;
                end else begin
                    tick_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            bus.dout      <= '0;
            bus.rx_done   <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            if (tick_clr)      tick_cnt <= '0;
            else if (tick_inc) tick_cnt <= tick_cnt + TW'(1);

            if (bit_clr)      bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + BW'(1);

            // Shifting in at the MSB leaves the first (LSB) bit at bit 0 after the last sample.
            if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};

            bus.rx_done <= load_out;
            if (load_out) begin
                bus.dout      <= shreg;
                bus.frame_err <= ~rx_s;
            end
        end
    end
endmodule
